ftdi_wr_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the FTDI FIFO byte writer.
- Grants the single writer to one requester for a burst of bytes.
- Issues one act pulse per byte and waits for the writer's done strobe before issuing the next byte.
- Rotates ownership round-robin and flags a stalled writer with a timeout error.

---
 rtl/ftdi_wr_arbiter_if.sv | 36 +++
 rtl/ftdi_wr_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ftdi_wr_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ftdi_wr_arbiter_if.sv
// Bundle of requester, status and writer-side signals for ftdi_wr_arbiter.
// The master modport is the arbiter's view; slave is the view of the
// requesters and FTDI byte writer that surround it.
interface ftdi_wr_arbiter_if;
  // Requester 0
  logic       iREQ0_n;
  logic [7:0] iDATA0;
  logic       iLAST0;
  logic       oACK0_n;
  // Requester 1
  logic       iREQ1_n;
  logic [7:0] iDATA1;
  logic       iLAST1;
  logic       oACK1_n;
  // Status
  logic [1:0] oGNT;
  logic       oBUSY_n;
  logic       oERR_n;
  // Byte writer
  logic       oACT_WR_n;
  logic [7:0] oWR_DATA;
  logic       iRUN_WR_n;
  logic       iDONE_WR_n;

  modport master (
    input  iREQ0_n, iDATA0, iLAST0, iREQ1_n, iDATA1, iLAST1,
    input  iRUN_WR_n, iDONE_WR_n,
    output oACK0_n, oACK1_n, oGNT, oBUSY_n, oERR_n, oACT_WR_n, oWR_DATA
  );

  modport slave (
    output iREQ0_n, iDATA0, iLAST0, iREQ1_n, iDATA1, iLAST1,
    output iRUN_WR_n, iDONE_WR_n,
    input  oACK0_n, oACK1_n, oGNT, oBUSY_n, oERR_n, oACT_WR_n, oWR_DATA
  );
endinterface

// File: rtl/ftdi_wr_arbiter.sv
// Two-requester arbiter/sequencer in front of the FTDI FIFO byte writer.
// A grant covers a burst of up to MAX_BURST bytes; each byte is one act
// strobe followed by a wait for the writer's done strobe. A writer that
// never answers within TIMEOUT cycles sets a sticky error and the grant is
// dropped. Ownership rotates round-robin between requesters.
// Build option: define ARB_FIXED_PRIO_EN to replace round-robin with fixed
// priority for requester 0.
module ftdi_wr_arbiter #(
  parameter int unsigned MAX_BURST = 16,   // 1..255
  parameter int unsigned TIMEOUT   = 1024  // >= 4
) (
  input  logic               clk,
  input  logic               rst,
  ftdi_wr_arbiter_if.master  bus
);

  localparam int unsigned   TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);
  localparam logic [7:0]    BURST_MAX = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_NEXT
  } state_t;

  state_t        state_q,   state_d;
  logic [1:0]    gnt_q,     gnt_d;
  logic [7:0]    bcnt_q,    bcnt_d;
  logic [TW-1:0] tcnt_q,    tcnt_d;
  logic          last_q,    last_d;
  logic          act_n_q,   act_n_d;
  logic          ack0_n_q,  ack0_n_d;
  logic          ack1_n_q,  ack1_n_d;
  logic          busy_n_q,  busy_n_d;
  logic          err_n_q,   err_n_d;
  logic [7:0]    wr_data_q, wr_data_d;
`ifndef ARB_FIXED_PRIO_EN
  logic          rr_q,      rr_d;      // 1: requester 1 wins the next tie
`endif

  logic          g_req_n;
  logic [7:0]    g_data;
  logic          g_last;
  logic          pick1;

  // View of the currently granted requester (grant is one-hot).
  always_comb begin
    g_req_n = bus.iREQ0_n;
    g_data  = bus.iDATA0;
    g_last  = bus.iLAST0;
    if (gnt_q[1]) begin
      g_req_n = bus.iREQ1_n;
      g_data  = bus.iDATA1;
      g_last  = bus.iLAST1;
    end
  end

  // Arbitration result used in IDLE: 1 selects requester 1.
  always_comb begin
    pick1 = 1'b0;
    if (!bus.iREQ1_n && bus.iREQ0_n) begin
      pick1 = 1'b1;
    end else if (!bus.iREQ0_n && !bus.iREQ1_n) begin
`ifdef ARB_FIXED_PRIO_EN
      pick1 = 1'b0;
`else
      pick1 = rr_q;
`endif
    end
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer latches.
    state_d   = state_q;
    gnt_d     = gnt_q;
    bcnt_d    = bcnt_q;
    tcnt_d    = tcnt_q;
    last_d    = last_q;
    wr_data_d = wr_data_q;
    err_n_d   = err_n_q;
    act_n_d   = 1'b1;
    ack0_n_d  = 1'b1;
    ack1_n_d  = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
    rr_d      = rr_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Writer must be idle so a byte left running by a reset completes first.
        if (bus.iRUN_WR_n && (!bus.iREQ0_n || !bus.iREQ1_n)) begin
          gnt_d   = pick1 ? 2'b10 : 2'b01;
          bcnt_d  = 8'd0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        act_n_d   = 1'b0;
        ack0_n_d  = ~gnt_q[0];
        ack1_n_d  = ~gnt_q[1];
        wr_data_d = g_data;
        last_d    = g_last;
        bcnt_d    = bcnt_q + 8'd1;
        tcnt_d    = '0;
        state_d   = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        // Done is tested first so it wins over the terminal count.
        if (!bus.iDONE_WR_n) begin
          state_d = S_NEXT;
        end else if (tcnt_q == T_LAST) begin
          err_n_d = 1'b0;
          gnt_d   = 2'b00;
`ifndef ARB_FIXED_PRIO_EN
          rr_d    = gnt_q[0];
`endif
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      S_NEXT: begin
        if (!g_req_n && !last_q && (bcnt_q < BURST_MAX)) begin
          state_d = S_ISSUE;
        end else begin
          gnt_d   = 2'b00;
`ifndef ARB_FIXED_PRIO_EN
          rr_d    = gnt_q[0];
`endif
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_n_d = (state_d == S_IDLE);
  end

  // State and registered outputs; synchronous reset has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 2'b00;
      bcnt_q    <= 8'd0;
      tcnt_q    <= '0;
      last_q    <= 1'b0;
      act_n_q   <= 1'b1;
      ack0_n_q  <= 1'b1;
      ack1_n_q  <= 1'b1;
      busy_n_q  <= 1'b1;
      err_n_q   <= 1'b1;
      wr_data_q <= 8'h00;
`ifndef ARB_FIXED_PRIO_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      bcnt_q    <= bcnt_d;
      tcnt_q    <= tcnt_d;
      last_q    <= last_d;
      act_n_q   <= act_n_d;
      ack0_n_q  <= ack0_n_d;
      ack1_n_q  <= ack1_n_d;
      busy_n_q  <= busy_n_d;
      err_n_q   <= err_n_d;
      wr_data_q <= wr_data_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign bus.oGNT      = gnt_q;
  assign bus.oBUSY_n   = busy_n_q;
  assign bus.oERR_n    = err_n_q;
  assign bus.oACT_WR_n = act_n_q;
  assign bus.oWR_DATA  = wr_data_q;
  assign bus.oACK0_n   = ack0_n_q;
  assign bus.oACK1_n   = ack1_n_q;

endmodule

// File: tb/tb_ftdi_wr_arbiter.sv
// Bench for ftdi_wr_arbiter: requester and writer models drive the bus,
// a scoreboard holds the byte order the writer must see, and a per-cycle
// compare process checks every act/ack against it plus protocol rules.
module tb_ftdi_wr_arbiter;

  localparam int MB       = 4;
  localparam int TO       = 8;
  localparam int DONE_LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ftdi_wr_arbiter_if bus ();

  ftdi_wr_arbiter #(.MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Expected writer byte stream: requester id and data, in issue order.
  typedef struct {
    bit         rid;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] rq0[$];   // {last, data} waiting at requester 0
  logic [8:0] rq1[$];
  bit         stall;    // writer holds off completion while set
  bit         w_busy;
  int         w_rem;
  int         act_cnt   = 0;
  int         gnt_drops = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input bit rid, input logic [7:0] d);
    exp_t e;
    e.rid  = rid;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Requester models: present the queue head, drop it on ack.
  initial begin
    logic [8:0] tmp;
    bit pres0, pres1;
    pres0 = 1'b0;
    pres1 = 1'b0;
    bus.iREQ0_n = 1'b1; bus.iDATA0 = 8'h00; bus.iLAST0 = 1'b0;
    bus.iREQ1_n = 1'b1; bus.iDATA1 = 8'h00; bus.iLAST1 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pres0 && !bus.oACK0_n) begin
        tmp = rq0.pop_front();
        pres0 = 1'b0;
        bus.iREQ0_n = 1'b1;
      end
      if (pres1 && !bus.oACK1_n) begin
        tmp = rq1.pop_front();
        pres1 = 1'b0;
        bus.iREQ1_n = 1'b1;
      end
      if (!pres0 && rq0.size() > 0) begin
        {bus.iLAST0, bus.iDATA0} = rq0[0];
        bus.iREQ0_n = 1'b0;
        pres0 = 1'b1;
      end
      if (!pres1 && rq1.size() > 0) begin
        {bus.iLAST1, bus.iDATA1} = rq1[0];
        bus.iREQ1_n = 1'b0;
        pres1 = 1'b1;
      end
    end
  end

  // Writer model: run low from act, done pulse DONE_LAT cycles later.
  initial begin
    bus.iRUN_WR_n  = 1'b1;
    bus.iDONE_WR_n = 1'b1;
    w_busy = 1'b0;
    w_rem  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.iDONE_WR_n) bus.iDONE_WR_n = 1'b1;
      if (w_busy) begin
        if (!stall) begin
          w_rem--;
          if (w_rem == 0) begin
            bus.iDONE_WR_n = 1'b0;
            bus.iRUN_WR_n  = 1'b1;
            w_busy = 1'b0;
          end
        end
      end else if (!bus.oACT_WR_n) begin
        w_busy = 1'b1;
        w_rem  = DONE_LAT;
        bus.iRUN_WR_n = 1'b0;
      end
    end
  end

  // Per-cycle compare against the scoreboard and protocol rules.
  initial begin
    exp_t       cur;
    logic [1:0] prev_gnt;
    logic       prev_act_n, prev_run_n;
    prev_gnt   = 2'b00;
    prev_act_n = 1'b1;
    prev_run_n = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("busy_matches_idle_grant", bus.oBUSY_n, (bus.oGNT == 2'b00));
        check("gnt_onehot", ($countones(bus.oGNT) <= 1), 1);
        if (!bus.oACT_WR_n) begin
          act_cnt++;
          check("act_one_cycle", prev_act_n, 1);
          check("act_writer_idle", prev_run_n, 1);
          check("act_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("wr_data", bus.oWR_DATA, cur.data);
            check("act_gnt", bus.oGNT, cur.rid ? 2'b10 : 2'b01);
            check("ack0_with_act", bus.oACK0_n, (cur.rid != 1'b0));
            check("ack1_with_act", bus.oACK1_n, (cur.rid != 1'b1));
          end
        end else begin
          check("ack_without_act", {bus.oACK1_n, bus.oACK0_n}, 2'b11);
        end
        if (prev_gnt != 2'b00 && bus.oGNT == 2'b00) gnt_drops++;
      end
      prev_gnt   = bus.oGNT;
      prev_act_n = bus.oACT_WR_n;
      prev_run_n = bus.iRUN_WR_n;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_act"},  bus.oACT_WR_n, 1);
    check({tag, "_ack0"}, bus.oACK0_n,   1);
    check({tag, "_ack1"}, bus.oACK1_n,   1);
    check({tag, "_busy"}, bus.oBUSY_n,   1);
    check({tag, "_err"},  bus.oERR_n,    1);
    check({tag, "_gnt"},  bus.oGNT,      2'b00);
    check({tag, "_data"}, bus.oWR_DATA,  8'h00);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && rq0.size() == 0 && rq1.size() == 0 &&
             bus.oBUSY_n && !w_busy) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, (n < budget), 1);
  endtask

  task automatic wait_act(input string name, input int budget);
    int n = 0;
    while (bus.oACT_WR_n && n < budget) begin
      tick();
      n++;
    end
    check(name, bus.oACT_WR_n, 0);
  endtask

  initial begin
    logic [1:0] g_s[10];
    logic       a_s[10], k_s[10], b_s[10];
    logic [7:0] d_s[10];
    int         a0, d0, k;

    rst   = 1'b1;
    stall = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Single byte A5 from requester 0, done 3 cycles after act.
    a0 = act_cnt;
    rq0.push_back({1'b1, 8'hA5});
    push_exp(1'b0, 8'hA5);
    for (int i = 1; i < 10; i++) begin
      tick();
      g_s[i] = bus.oGNT;  a_s[i] = bus.oACT_WR_n; k_s[i] = bus.oACK0_n;
      b_s[i] = bus.oBUSY_n; d_s[i] = bus.oWR_DATA;
    end
    check("single_gnt_before", g_s[1], 2'b00);
    check("single_gnt_set",    g_s[2], 2'b01);
    check("single_no_act_yet", a_s[2], 1);
    check("single_act_low",    a_s[3], 0);
    check("single_ack0_low",   k_s[3], 0);
    check("single_data",       d_s[3], 8'hA5);
    check("single_act_pulse",  a_s[4], 1);
    check("single_ack_pulse",  k_s[4], 1);
    check("single_gnt_next",   g_s[7], 2'b01);
    check("single_busy_next",  b_s[7], 0);
    check("single_gnt_rel",    g_s[8], 2'b00);
    check("single_busy_rel",   b_s[8], 1);
    wait_quiet("single", 50);
    check("single_act_count", act_cnt - a0, 1);

    // Contention from reset: two 2-byte bursts.
    pulse_reset();
    rq0.push_back({1'b0, 8'h10}); rq0.push_back({1'b1, 8'h11});
    rq1.push_back({1'b0, 8'h20}); rq1.push_back({1'b1, 8'h21});
    push_exp(1'b0, 8'h10); push_exp(1'b0, 8'h11);
    push_exp(1'b1, 8'h20); push_exp(1'b1, 8'h21);
    wait_quiet("contend1", 100);
    rq0.push_back({1'b1, 8'h30});
    push_exp(1'b0, 8'h30);
    wait_quiet("contend2", 50);
    rq0.push_back({1'b1, 8'h50});
    rq1.push_back({1'b1, 8'h40});
`ifdef ARB_FIXED_PRIO_EN
    push_exp(1'b0, 8'h50); push_exp(1'b1, 8'h40);
`else
    push_exp(1'b1, 8'h40); push_exp(1'b0, 8'h50);
`endif
    wait_quiet("contend3", 100);

    // Burst cap: 6 bytes with last=0 from requester 1, cap of 4.
    a0 = act_cnt;
    d0 = gnt_drops;
    for (int i = 0; i < 6; i++) begin
      rq1.push_back({1'b0, 8'(8'h60 + i)});
      push_exp(1'b1, 8'(8'h60 + i));
    end
    wait_quiet("burst", 200);
    check("burst_act_count", act_cnt - a0, 6);
    check("burst_releases",  gnt_drops - d0, 2);

    // Timeout: writer never completes.
    stall = 1'b1;
    rq0.push_back({1'b1, 8'hC3});
    push_exp(1'b0, 8'hC3);
    wait_act("timeout_act_seen", 20);
    k = 0;
    while (bus.oERR_n && k < 30) begin
      tick();
      k++;
    end
    check("timeout_err_latency", k, TO);
    check("timeout_gnt",  bus.oGNT,    2'b00);
    check("timeout_busy", bus.oBUSY_n, 1);
    stall = 1'b0;
    a0 = act_cnt;
    repeat (10) tick();
    check("timeout_err_sticky", bus.oERR_n, 0);
    check("timeout_no_reissue", act_cnt - a0, 0);
    pulse_reset();
    check("timeout_err_cleared", bus.oERR_n, 1);

    // Reset while the writer is still running.
    stall = 1'b1;
    rq0.push_back({1'b1, 8'h77});
    push_exp(1'b0, 8'h77);
    wait_act("midrst_act_seen", 20);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    a0 = act_cnt;
    rq0.push_back({1'b1, 8'h78});
    push_exp(1'b0, 8'h78);
    repeat (8) tick();
    check("midrst_held_off", act_cnt - a0, 0);
    check("midrst_idle",     bus.oBUSY_n, 1);
    stall = 1'b0;
    wait_quiet("midrst", 50);
    check("midrst_resumed", act_cnt - a0, 1);

    // Both requesters streaming 1-byte bursts.
    pulse_reset();
    rq0.push_back({1'b1, 8'h80}); rq0.push_back({1'b1, 8'h81}); rq0.push_back({1'b1, 8'h82});
    rq1.push_back({1'b1, 8'h90}); rq1.push_back({1'b1, 8'h91});
`ifdef ARB_FIXED_PRIO_EN
    push_exp(1'b0, 8'h80); push_exp(1'b0, 8'h81); push_exp(1'b0, 8'h82);
    push_exp(1'b1, 8'h90); push_exp(1'b1, 8'h91);
`else
    push_exp(1'b0, 8'h80); push_exp(1'b1, 8'h90); push_exp(1'b0, 8'h81);
    push_exp(1'b1, 8'h91); push_exp(1'b0, 8'h82);
`endif
    wait_quiet("prio", 200);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
